mem_sys: RTL and testbench
==========================

# mem_sys

Unified memory and I/O subsystem that sits directly below the processor core and serves its single 16-bit memory port (`addr`, `we`, `toMem` → `wdata`; `rdata` → `fromMem`). It holds a word-addressed program/data RAM and a memory-mapped console transmit FIFO. The FIFO drains over a valid/ready byte stream. A load port lets the bench or boot logic fill RAM while the core is held in reset.

## Interface
Parameters:
- `AW`, 11: RAM word-address width; RAM holds 2^AW 16-bit words.
- `FIFO_DEPTH`, 8: console FIFO entries; must be a power of two, at most 8.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `we` in 1: core write enable.
- `addr` in 16: core word address.
- `wdata` in 16: core write data.
- `rdata` out 16: registered read data, connected to the core's `fromMem`.
- `load_we` in 1: loader write strobe.
- `load_addr` in AW: loader word address.
- `load_data` in 16: loader write data.
- `out_valid` out 1: console byte available.
- `out_data` out 8: console byte at the FIFO head.
- `out_ready` in 1: consumer accepts the byte.
- `drop_cnt` out 8: count of console bytes lost to overflow; saturates at 255.

## Operation
Address decode on `addr`:
- **RAM:** `addr[15]==0`. Word index is `addr[AW-1:0]`; bits `[14:AW]` are ignored, so RAM aliases.
- **CONSOLE_DATA:** `addr==16'hFF00`.
  - Write pushes `wdata[7:0]`; `wdata[15:8]` is ignored.
  - Read returns `16'h0000`.
- **CONSOLE_STATUS:** `addr==16'hFF01`.
  - Read returns `{drop_cnt, 3'b000, full, count[3:0]}`, where `count` is 0..FIFO_DEPTH.
  - Write is ignored.
- **Unmapped:** all other addresses read `16'h0000`; writes are ignored.

RAM:
- Single-port synchronous array with no reset; contents survive `rst`.
- Write happens at the edge where `we==1` and `addr` decodes to RAM.
- Read is read-first: a same-edge read and write to the same word returns the old data.
- Loader priority: if `load_we==1`, RAM writes `load_data` at `load_addr`, and any core RAM write that cycle is dropped.
  - Core reads still occur normally during a load.

Console FIFO:
- Circular buffer with read and write pointers plus a `count` register.
- **Push:** a core write to CONSOLE_DATA.
- **Pop:** `out_valid && out_ready`.
- Push when not full is accepted.
- Push when full with no same-cycle pop is dropped, and `drop_cnt` increments (saturating).
- Push when full with a same-cycle pop is accepted; `count` stays FIFO_DEPTH.
- Push and pop on a non-empty FIFO: both occur; `count` is unchanged.
- Pop on empty is impossible because `out_valid==0`.
- `full = (count==FIFO_DEPTH)`.
- `out_valid = (count!=0)`.
- `out_data` is the head entry when `out_valid`, otherwise `8'h00`.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Read latency:** 1 cycle.
  - `rdata` at edge N+1 reflects `addr` sampled at edge N: RAM contents before any edge-N write, or the status/zero value.
  - `rdata` is registered and updates every cycle.
- **Write:** takes effect at the sampling edge. A read of the same word on the next cycle returns the new value.
- **Status reads** sample `count`, `full` and `drop_cnt` before the same-edge push/pop update.
- **Console handshake:**
  - `out_data` is held stable while `out_valid && !out_ready`.
  - A byte pushed at edge N is visible on `out_valid`/`out_data` after edge N (same-cycle visibility from register outputs).
  - Back-to-back pops at one byte/cycle are sustained.
- **Reset values** (immediate on `rst` assertion, independent of `clk`):
  - `rdata=0`, `out_valid=0`, `out_data=0`, `drop_cnt=0`.
  - FIFO pointers and `count` are 0.
- **Reset mid-operation:** queued console bytes are discarded and a partially accepted handshake is abandoned. RAM keeps its contents, and any loader or core write on that edge is not guaranteed.

## Test plan
- **Load and read back:** load `16'hC105` at word 0 and `16'h1234` at word 5, then deassert `load_we`. Core read of `addr=0` gives `rdata==16'hC105` one cycle later; `addr=16'h0805` (alias, AW=11) gives `16'h1234`.
- **Read-first and write/readback:** core write `16'hBEEF` to word 3 with the old value `16'h0001`, reading word 3 on the same cycle. `rdata==16'h0001` the next cycle, then `16'hBEEF` on the following read. Loader and core writing word 3 on the same cycle: loader data wins.
- **Console FIFO:** with `out_ready=0`, push bytes `8'h41..8'h48` (8 pushes) to `16'hFF00`.
  - Status read gives `16'h0018` (full, count 8).
  - A ninth push gives `drop_cnt==1`.
  - Raise `out_ready`: bytes `41..48` appear in order, one per cycle, then `out_valid==0`.
- **Full with simultaneous push+pop:** fill the FIFO, then push `8'h5A` while popping. `drop_cnt` is unchanged, `count` stays 8, and `8'h5A` drains last.
- **Saturation and reset:** 300 overflow pushes give `drop_cnt==255`. Asserting `rst` mid-stream clears `out_valid`, `out_data` and `drop_cnt` without a clock edge. A RAM word written before the reset reads back unchanged after it.

Source files
------------

// File: rtl/mem_sys.sv
// Memory and I/O subsystem below the core: word RAM with a loader port and a memory-mapped console transmit FIFO.
// Reads are registered (1 cycle); the console byte stream is valid/ready, and pushes into a full FIFO are counted as drops.
module mem_sys #(
  parameter int AW         = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [15:0]   addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic [7:0]    drop_cnt
);

  localparam int            PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]    DEPTH = 4'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic          sel_ram;
  logic          sel_cdata;
  logic          sel_cstat;
  logic [AW-1:0] ram_idx;

  assign sel_ram   = ~addr[15];
  assign sel_cdata = (addr == 16'hFF00);
  assign sel_cstat = (addr == 16'hFF01);
  assign ram_idx   = addr[AW-1:0];

  logic [15:0] ram [2**AW];

  // Loader wins over the core; the core's read still proceeds below.
  always_ff @(posedge clk) begin
    if (load_we)
      ram[load_addr] <= load_data;
    else if (we && sel_ram)
      ram[ram_idx] <= wdata;
  end

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [3:0]    count;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          drop;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  assign full      = (count == DEPTH);
  assign out_valid = (count != 4'd0);
  assign out_data  = out_valid ? fifo_mem[rptr] : 8'h00;
  assign pop       = out_valid & out_ready;
  assign push_req  = we & sel_cdata;
  // When full, a same-cycle pop frees the head slot, which is exactly where wptr points.
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= 4'd0;
      drop_cnt <= 8'd0;
    end else begin
      if (push)
        wptr <= ptr_inc(wptr);
      if (pop)
        rptr <= ptr_inc(rptr);
      if (push && !pop)
        count <= count + 4'd1;
      else if (!push && pop)
        count <= count - 4'd1;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  logic [15:0] rdata_nxt;

  always_comb begin
    rdata_nxt = 16'h0000;
    if (sel_ram)
      rdata_nxt = ram[ram_idx];
    else if (sel_cstat)
      rdata_nxt = {drop_cnt, 3'b000, full, count};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= 16'h0000;
    else
      rdata <= rdata_nxt;
  end

endmodule

// File: tb/tb_mem_sys.sv
// Directed bench for mem_sys: a queue/array model checked every cycle plus literal expectations per scenario.
module tb_mem_sys;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        load_we = 1'b0;
  logic [10:0] load_addr = 11'd0;
  logic [15:0] load_data = 16'h0000;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  mem_sys #(.AW(11), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RAM image with known-bits, console queue, drop counter.
  logic [15:0] m_ram [2048];
  bit          m_known_w [2048];
  logic [7:0]  m_q [$];
  logic [7:0]  m_drop = 8'd0;
  logic [15:0] m_rdata = 16'h0000;
  bit          m_rknown = 1'b1;

  always @(posedge clk or posedge rst) begin : model
    int  sz;
    bit  do_pop;
    if (rst) begin
      m_q.delete();
      m_drop   = 8'd0;
      m_rdata  = 16'h0000;
      m_rknown = 1'b1;
    end else begin
      sz = m_q.size();
      m_rknown = 1'b1;
      if (addr[15] == 1'b0) begin
        m_rdata  = m_ram[addr[10:0]];
        m_rknown = m_known_w[addr[10:0]];
      end else if (addr == 16'hFF01)
        m_rdata = {m_drop, 3'b000, (sz == 8), 4'(sz)};
      else
        m_rdata = 16'h0000;
      do_pop = (sz != 0) && out_ready;
      if (do_pop)
        void'(m_q.pop_front());
      if (we && addr == 16'hFF00) begin
        if (sz < 8 || do_pop)
          m_q.push_back(wdata[7:0]);
        else if (m_drop != 8'd255)
          m_drop = m_drop + 8'd1;
      end
      if (load_we) begin
        m_ram[load_addr] = load_data;
        m_known_w[load_addr] = 1'b1;
      end else if (we && addr[15] == 1'b0) begin
        m_ram[addr[10:0]] = wdata;
        m_known_w[addr[10:0]] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_rknown)
        check("model_rdata", rdata, m_rdata);
      check("model_out_valid", {15'd0, out_valid}, {15'd0, m_q.size() != 0});
      check("model_out_data", {8'd0, out_data}, {8'd0, (m_q.size() != 0) ? m_q[0] : 8'h00});
      check("model_drop_cnt", {8'd0, drop_cnt}, {8'd0, m_drop});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [10:0] a, input logic [15:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    cyc();
    load_we = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    we = 1'b1; addr = 16'hFF00; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  logic [7:0] seq_a [8];

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_rdata", rdata, 16'h0000);
    check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_out_data", {8'd0, out_data}, 16'h0000);
    check("rst_drop_cnt", {8'd0, drop_cnt}, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Loader fill and read back, including an alias above AW.
    load(11'd0, 16'hC105);
    load(11'd5, 16'h1234);
    load(11'd3, 16'h0001);
    addr = 16'h0000; cyc();
    check("ld_word0", rdata, 16'hC105);
    addr = 16'h0805; cyc();
    check("ld_alias5", rdata, 16'h1234);

    // Read-first then readback.
    we = 1'b1; addr = 16'h0003; wdata = 16'hBEEF; cyc();
    we = 1'b0;
    check("read_first", rdata, 16'h0001);
    cyc();
    check("write_readback", rdata, 16'hBEEF);

    // Loader and core collide on word 3.
    load_we = 1'b1; load_addr = 11'd3; load_data = 16'h7777;
    we = 1'b1; wdata = 16'h2222; cyc();
    load_we = 1'b0; we = 1'b0;
    cyc();
    check("loader_wins", rdata, 16'h7777);

    // Console: fill with upper byte garbage that must be ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push({8'hA5, 8'(8'h41 + i)});
    addr = 16'hFF01; cyc();
    check("status_full", rdata, 16'h0018);
    check("head_41", {8'd0, out_data}, 16'h0041);
    push(16'h0049);
    check("drop_one", {8'd0, drop_cnt}, 16'h0001);
    addr = 16'hFF00; cyc();
    check("cdata_reads_zero", rdata, 16'h0000);
    addr = 16'hFF01; cyc();
    check("status_drop", rdata, 16'h0118);
    addr = 16'h1234 | 16'hF000; cyc();
    check("unmapped_zero", rdata, 16'h0000);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {15'd0, out_valid}, 16'h0001);
      check("drain_data", {8'd0, out_data}, {8'd0, 8'(8'h41 + i)});
      cyc();
    end
    check("drained_valid", {15'd0, out_valid}, 16'h0000);
    check("drained_data", {8'd0, out_data}, 16'h0000);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) push({8'h00, 8'(8'h61 + i)});
    we = 1'b1; addr = 16'hFF00; wdata = 16'h005A; out_ready = 1'b1; cyc();
    we = 1'b0; out_ready = 1'b0; addr = 16'hFF01; cyc();
    check("pushpop_status", rdata, 16'h0118);
    seq_a = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pushpop_order", {8'd0, out_data}, {8'd0, seq_a[i]});
      cyc();
    end
    check("pushpop_empty", {15'd0, out_valid}, 16'h0000);
    out_ready = 1'b0;

    // Saturation then asynchronous reset mid-stream.
    for (int i = 0; i < 8; i++) push({8'h00, 8'(8'h70 + i)});
    for (int i = 0; i < 300; i++) push(16'h00EE);
    check("drop_saturated", {8'd0, drop_cnt}, 16'h00FF);
    out_ready = 1'b1; we = 1'b1; addr = 16'hFF00; wdata = 16'h0011; cyc();
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("midrst_out_data", {8'd0, out_data}, 16'h0000);
    check("midrst_drop_cnt", {8'd0, drop_cnt}, 16'h0000);
    check("midrst_rdata", rdata, 16'h0000);
    we = 1'b0; out_ready = 1'b0; addr = 16'h0000;
    @(posedge clk);
    #1 rst = 1'b0;
    addr = 16'h0003; cyc();
    check("ram_survives_rst", rdata, 16'h7777);
    push(16'h0099);
    check("post_rst_valid", {15'd0, out_valid}, 16'h0001);
    check("post_rst_data", {8'd0, out_data}, 16'h0099);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
